hyperbus_mem_responder: RTL
===========================

HYPERBUS_MEM_RESPONDER -- requirements
Module: hyperbus_mem_responder

Interface
REQ-001 SHALL have parameter HBUS_ADDR_WIDTH, default 32, meaning word-address width of the native interface.
REQ-002 SHALL have parameter HBUS_DATA_WIDTH, default 16, meaning data word width.
REQ-003 SHALL have parameter MEM_ADDR_WIDTH, default 10, meaning log2 of backing-memory depth in words.
REQ-004 SHALL have parameter LATENCY, default 6, meaning initial-access latency in cycles (range 2..15).
REQ-005 SHALL have parameter RECOVERY, default 2, meaning idle turnaround cycles after each burst (range 1..7).
REQ-006 hbus_clk  input  1  sole clock; one clock, all logic on rising edge.
REQ-007 hbus_rst  input  1  reset; synchronous, active-high.
REQ-008 hbus_adr_i  input  HBUS_ADDR_WIDTH  burst start word address, sampled at request accept.
REQ-009 hbus_dat_i  input  HBUS_DATA_WIDTH  write data from initiator.
REQ-010 hbus_dat_o  output  HBUS_DATA_WIDTH  read data, qualified by hbus_valid.
REQ-011 hbus_rrq  input  1  read request, held high for the burst.
REQ-012 hbus_wrq  input  1  write request, held high for the burst.
REQ-013 hbus_ready  output  1  write beat accept.
REQ-014 hbus_valid  output  1  read beat valid.
REQ-015 hbus_busy  output  1  responder not idle.

Function
REQ-016 SHALL implement states IDLE, LAT, READ, WRITE, RECOV; one-hot encoding.
REQ-017 IDLE: on sampled hbus_rrq, latch address, busy<=1, load latency counter, go LAT with direction=read; else on hbus_wrq, same with direction=write; rrq SHALL win if both are high.
REQ-018 LAT: counter decrements each cycle; after LATENCY cycles go READ or WRITE; a RAM read of the current address SHALL issue in the last LAT cycle.
REQ-019 LAT: if the request for the latched direction is sampled low, SHALL abort with no memory access and go RECOV.
REQ-020 READ: each cycle the request is sampled high SHALL assert hbus_valid with hbus_dat_o=mem[addr] (registered) and increment addr; the first beat appears in the first READ cycle.
REQ-021 READ: request sampled low -> valid<=0, go RECOV; extra beats already issued are harmless (initiator discards them).
REQ-022 WRITE: hbus_ready SHALL be high for every WRITE cycle; at each edge with hbus_wrq & hbus_ready, mem[addr]<=hbus_dat_i and addr increments.
REQ-023 WRITE: wrq sampled low -> ready<=0, no write, go RECOV.
REQ-024 Address arithmetic SHALL use the low MEM_ADDR_WIDTH bits of hbus_adr_i and wrap modulo 2^MEM_ADDR_WIDTH; upper bits ignored.
REQ-025 RECOV: hold RECOVERY cycles, busy high, requests ignored, then IDLE with busy<=0.
REQ-026 hbus_valid and hbus_ready SHALL never be high in the same cycle; all outputs registered.
REQ-027 A new request held high across RECOV SHALL be accepted on the first IDLE cycle.

Reset
REQ-028 On hbus_rst sampled high: state IDLE; hbus_ready, hbus_valid, hbus_busy = 0; hbus_dat_o = 0; counters and addr = 0.
REQ-029 Reset mid-burst SHALL abort the burst with no further writes; memory contents SHALL be retained, not cleared.

Configuration
REQ-030 Macro HYPERBUS_RESP_LATENCY_X2_EN: when defined, every access SHALL spend 2*LATENCY cycles in LAT (HyperRAM fixed double latency); when undefined, LATENCY cycles; no port changes either way.

Structure
REQ-031 Shared package hyperbus_pkg SHALL hold state encodings, CMD_READ/CMD_WRITE constants and latency/recovery counter widths.
REQ-032 Backing store SHALL be sub-module hyperbus_resp_ram: single-port synchronous RAM, 1-cycle read latency, write-enable, depth 2^MEM_ADDR_WIDTH.

Verification
REQ-033 Write burst: wrq high, adr 0x10, data 0xA5A5,0x5A5A, drop wrq after 2nd ready -> ready rises LATENCY cycles after accept, mem[0x10]=0xA5A5, mem[0x11]=0x5A5A, nothing at 0x12.
REQ-034 Read-back: rrq at 0x10, 2 beats -> valid first high LATENCY cycles after accept, dat_o 0xA5A5 then 0x5A5A, busy low RECOVERY cycles after rrq drop.
REQ-035 Wrap: write 0xBEEF to adr 0x3FF then 0xCAFE (2 beats) -> mem[0x3FF]=0xBEEF, mem[0x000]=0xCAFE; adr 0x400 aliases 0x000.
REQ-036 Abort and priority: rrq and wrq high together -> read executes; separate wrq dropped during LAT -> no memory change, RECOV entered.
REQ-037 Reset mid-write after 1 beat of 4 -> outputs 0 next cycle, only first word written, earlier contents intact.
REQ-038 Rebuild with HYPERBUS_RESP_LATENCY_X2_EN -> first ready/valid at 12 cycles after accept for LATENCY=6; data identical.

Source files
------------

// File: rtl/hyperbus_mem_responder_pkg.sv
// Shared definitions for the HyperBus memory responder: one-hot FSM states,
// transfer direction codes and latency/recovery counter widths.
package hyperbus_pkg;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_LAT   = 5'b00010,
    ST_READ  = 5'b00100,
    ST_WRITE = 5'b01000,
    ST_RECOV = 5'b10000
  } state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Wide enough for the doubled latency of 2*15 cycles.
  localparam int LAT_CNT_W = 5;
  localparam int REC_CNT_W = 3;

endpackage

// File: rtl/hyperbus_mem_responder_if.sv
// Native burst interface between an initiator (master) and the memory responder (slave).
// Read beats are qualified by hbus_valid, write beats are accepted while hbus_ready is high.
interface hyperbus_mem_responder_if #(
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16
);
  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i;
  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i;
  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o;
  logic                       hbus_rrq;
  logic                       hbus_wrq;
  logic                       hbus_ready;
  logic                       hbus_valid;
  logic                       hbus_busy;

  modport master (
    output hbus_adr_i, hbus_dat_i, hbus_rrq, hbus_wrq,
    input  hbus_dat_o, hbus_ready, hbus_valid, hbus_busy
  );

  modport slave (
    input  hbus_adr_i, hbus_dat_i, hbus_rrq, hbus_wrq,
    output hbus_dat_o, hbus_ready, hbus_valid, hbus_busy
  );
endinterface

// File: rtl/hyperbus_resp_ram.sv
// Single-port synchronous RAM, 1-cycle read latency; only the read register is reset,
// the array keeps its contents across reset.
module hyperbus_resp_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/hyperbus_mem_responder.sv
// HyperBus-style memory responder: first beat LATENCY cycles after accept (2*LATENCY with
// HYPERBUS_RESP_LATENCY_X2_EN), then one beat per cycle while the request is held; RECOVERY idle cycles after each burst.
module hyperbus_mem_responder
  import hyperbus_pkg::*;
#(
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16,
  parameter int MEM_ADDR_WIDTH  = 10,
  parameter int LATENCY         = 6,
  parameter int RECOVERY        = 2
) (
  input logic                    hbus_clk,
  input logic                    hbus_rst,
  hyperbus_mem_responder_if.slave bus
);

`ifdef HYPERBUS_RESP_LATENCY_X2_EN
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(2 * LATENCY);
`else
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LATENCY);
`endif
  localparam logic [REC_CNT_W-1:0] REC_LOAD = REC_CNT_W'(RECOVERY);

  state_t                      state;
  logic                        dir;
  logic [MEM_ADDR_WIDTH-1:0]   addr;
  logic [LAT_CNT_W-1:0]        lat_cnt;
  logic [REC_CNT_W-1:0]        rec_cnt;
  logic                        ready;
  logic                        valid;
  logic                        busy;
  logic                        req_live;
  logic                        lat_last;
  logic                        ram_we;
  logic                        ram_re;
  logic [HBUS_DATA_WIDTH-1:0]  ram_q;
  logic                        unused_adr_hi;

  // Address arithmetic only ever sees the low bits; the rest alias.
  assign unused_adr_hi = ^bus.hbus_adr_i[HBUS_ADDR_WIDTH-1:MEM_ADDR_WIDTH];

  assign req_live = (dir == CMD_READ) ? bus.hbus_rrq : bus.hbus_wrq;
  assign lat_last = (state == ST_LAT) && (lat_cnt == LAT_CNT_W'(1));

  assign ram_we = !hbus_rst && (state == ST_WRITE) && bus.hbus_wrq;
  assign ram_re = !hbus_rst && bus.hbus_rrq &&
                  ((lat_last && dir == CMD_READ) || (state == ST_READ));

  hyperbus_resp_ram #(
    .ADDR_WIDTH (MEM_ADDR_WIDTH),
    .DATA_WIDTH (HBUS_DATA_WIDTH)
  ) u_ram (
    .clk   (hbus_clk),
    .rst   (hbus_rst),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr),
    .wdata (bus.hbus_dat_i),
    .rdata (ram_q)
  );

  always_ff @(posedge hbus_clk) begin
    if (hbus_rst) begin
      state   <= ST_IDLE;
      dir     <= CMD_READ;
      addr    <= '0;
      lat_cnt <= '0;
      rec_cnt <= '0;
      ready   <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.hbus_rrq || bus.hbus_wrq) begin
            addr    <= bus.hbus_adr_i[MEM_ADDR_WIDTH-1:0];
            dir     <= bus.hbus_rrq ? CMD_READ : CMD_WRITE;
            lat_cnt <= LAT_LOAD;
            busy    <= 1'b1;
            state   <= ST_LAT;
          end
        end
        ST_LAT: begin
          if (!req_live) begin
            rec_cnt <= REC_LOAD;
            state   <= ST_RECOV;
          end else if (lat_last) begin
            // The read of the first word is issued on this edge so beat 0 lands with valid.
            if (dir == CMD_READ) begin
              valid <= 1'b1;
              addr  <= addr + MEM_ADDR_WIDTH'(1);
              state <= ST_READ;
            end else begin
              ready <= 1'b1;
              state <= ST_WRITE;
            end
          end else begin
            lat_cnt <= lat_cnt - LAT_CNT_W'(1);
          end
        end
        ST_READ: begin
          if (bus.hbus_rrq) begin
            addr <= addr + MEM_ADDR_WIDTH'(1);
          end else begin
            valid   <= 1'b0;
            rec_cnt <= REC_LOAD;
            state   <= ST_RECOV;
          end
        end
        ST_WRITE: begin
          if (bus.hbus_wrq) begin
            addr <= addr + MEM_ADDR_WIDTH'(1);
          end else begin
            ready   <= 1'b0;
            rec_cnt <= REC_LOAD;
            state   <= ST_RECOV;
          end
        end
        ST_RECOV: begin
          if (rec_cnt == REC_CNT_W'(1)) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            rec_cnt <= rec_cnt - REC_CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.hbus_ready = ready;
  assign bus.hbus_valid = valid;
  assign bus.hbus_busy  = busy;
  assign bus.hbus_dat_o = ram_q;

endmodule
